spi_ram_ctrl_arb: RTL and testbench
===================================

// Module: spi_ram_ctrl_arb
// PURPOSE
//  Two-requester round-robin controller in front of the SPI RAM's 10-bit command port.
//  Accepts whole read/write transactions and sequences them into the RAM's two-command form:
//   write = {00,addr} then {01,data}; read = {10,addr} then {11,x}, then capture dout on tx_valid.
//  Sits between the SPI slave path (requester 0) and the local debug/BIST port (requester 1).
// PARAMETERS
//  ADDR_SIZE    8  address and data width of the RAM (command word is ADDR_SIZE+2 bits)
//  TIMEOUT_CYC  4  cycles RD_WAIT waits for ram_tx_valid before flagging an error (>=1)
// PORTS
//  clk          in   1            single clock, rising edge
//  rst          in   1            synchronous, active-high reset
//  req_valid    in   2            per-requester transaction valid; held with fields until ready
//  req_ready    out  2            per-requester accept; handshake = valid & ready
//  req_we       in   2            per-requester 1=write, 0=read
//  req_addr     in   2*ADDR_SIZE  per-requester address, requester i at [i*ADDR_SIZE +: ADDR_SIZE]
//  req_wdata    in   2*ADDR_SIZE  per-requester write data, same packing
//  rsp_valid    out  2            one-cycle completion pulse to the owning requester
//  rsp_rdata    out  ADDR_SIZE    read data, valid with rsp_valid (shared bus)
//  rsp_err      out  1            read timed out, valid with rsp_valid
//  ram_din      out  ADDR_SIZE+2  command word to RAM ([9:8] opcode)
//  ram_rx_valid out  1            command strobe to RAM
//  ram_dout     in   ADDR_SIZE    RAM read data
//  ram_tx_valid in   1            RAM read-data valid (level; cleared by next non-11 command)
// BEHAVIOUR
//  Reset: state=IDLE; ram_rx_valid=0, ram_din=0, rsp_valid=0, rsp_rdata=0, rsp_err=0; last_gnt=1.
//   req_ready is 0 while rst=1.
//  req_ready: combinational, nonzero only in IDLE, one-hot to the arbitration winner.
//  Arbitration: one requester valid -> it wins. Both valid -> the one != last_gnt wins.
//   last_gnt updates on each handshake only.
//  Handshake in IDLE at cycle N: latch id/we/addr/wdata.
//  Write FSM: IDLE -> WR_ADDR -> WR_DATA -> DONE -> IDLE.
//   N+1: {00,addr} on ram_din. N+2: {01,wdata} on ram_din.
//  Read FSM: IDLE -> RD_ADDR -> RD_CMD -> RD_WAIT -> DONE -> IDLE.
//   N+1: {10,addr}. N+2: {11,0}.
//  Issue states: ram_din and ram_rx_valid are registered. ram_rx_valid=1 for exactly one cycle
//   per command, 0 in all other states.
//  RD_WAIT: sample ram_tx_valid each cycle; the first sample is cycle N+3.
//   On 1: capture ram_dout and go to DONE.
//   Counter reaches TIMEOUT_CYC with no tx_valid: set err and go to DONE.
//   Stale tx_valid is impossible: the {10,addr} command has already cleared it.
//  DONE: rsp_valid[id]=1 for one cycle with rsp_rdata/rsp_err (write: rdata=0, err=0); go to IDLE.
//   Nominal latency, handshake to rsp_valid: write 3 cycles, read 4 cycles.
//  Throughput: a new handshake is possible in the cycle after DONE (next IDLE).
//   Minimum spacing: write 4, read 5 cycles.
//  req_valid dropped before ready: request vanishes, no error.
//   Fields changing after the handshake are ignored (latched).
//  Reset mid-transaction: immediate return to IDLE, no rsp pulse, transaction dropped.
//   A partially updated RAM write/read address is acceptable.
//  Address 0 and ADDR max (8'hFF) have no special handling; no address wrap is generated here.
// STRUCTURE
//  spi_ram_pkg: typedef enum logic[1:0] ram_cmd_e {CMD_WR_ADDR=00, CMD_WR_DATA=01,
//   CMD_RD_ADDR=10, CMD_RD_DATA=11}; typedef enum state_e {IDLE, WR_ADDR, WR_DATA, RD_ADDR,
//   RD_CMD, RD_WAIT, DONE}.
//  Sub-module rr_arb2: 2-way round-robin arbiter (req[1:0], update, gnt[1:0], last_gnt reg).
//  Top: FSM, request latch, timeout counter, response regs. Pair the bench with the SPI_RAM model.
// TESTING
//  1. R0 write addr 8'h3C data 8'hA5, then read 8'h3C -> rsp_valid[0] at +3 and +4,
//     rsp_rdata=8'hA5, err=0.
//  2. Both valid in the same cycle after reset (last_gnt=1) -> R0 granted first, R1 next.
//     Hold both -> grants alternate 0,1,0,1.
//  3. Read with ram_tx_valid forced 0 -> rsp_valid at +3+TIMEOUT_CYC, rsp_err=1; next read is
//     normal with err=0.
//  4. R1 write 8'hFF<=8'h5A, then R0 read 8'hFF -> 8'h5A; command trace 00FF,015A,10FF,1100
//     with one-cycle strobes.
//  5. Assert rst in RD_CMD -> next cycle IDLE, ram_rx_valid=0, no rsp_valid; following write
//     completes normally.
//  6. Requester drops valid before grant, or changes addr after handshake -> no transaction,
//     or latched addr used respectively.

Source files
------------

// File: rtl/spi_ram_ctrl_arb_pkg.sv
// Shared types for the SPI RAM command-port controller: RAM opcodes, controller
// states and small helpers used by the top and its arbiter.
package spi_ram_ctrl_arb_pkg;

    localparam int DEF_ADDR_SIZE   = 8;
    localparam int DEF_TIMEOUT_CYC = 4;

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } ram_cmd_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ADDR = 3'd1,
        WR_DATA = 3'd2,
        RD_ADDR = 3'd3,
        RD_CMD  = 3'd4,
        RD_WAIT = 3'd5,
        DONE    = 3'd6
    } state_e;

    function automatic logic [1:0] id_onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/spi_ram_ctrl_arb_if.sv
// Bundle of the two requester ports plus the RAM command port. The "slave" modport
// is the controller's view; "master" is the requesters plus RAM side.
interface spi_ram_ctrl_arb_if #(
    parameter int ADDR_SIZE = 8
);
    // Requests: a transfer happens on a rising edge where req_valid[i] & req_ready[i];
    // the requester holds valid and all fields stable until then, and may withdraw
    // valid before that edge. rsp_valid[i] is a one-cycle pulse with no back-pressure.
    logic [1:0]             req_valid;
    logic [1:0]             req_ready;
    logic [1:0]             req_we;
    logic [2*ADDR_SIZE-1:0] req_addr;
    logic [2*ADDR_SIZE-1:0] req_wdata;
    logic [1:0]             rsp_valid;
    logic [ADDR_SIZE-1:0]   rsp_rdata;
    logic                   rsp_err;
    logic [ADDR_SIZE+1:0]   ram_din;
    logic                   ram_rx_valid;
    logic [ADDR_SIZE-1:0]   ram_dout;
    logic                   ram_tx_valid;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, ram_dout, ram_tx_valid,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, ram_din, ram_rx_valid
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, ram_dout, ram_tx_valid,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, ram_din, ram_rx_valid
    );

endinterface

// File: rtl/spi_ram_ctrl_arb_rr_arb2.sv
// Two-way round-robin arbiter: on contention the requester that did not win last
// time is granted. The history bit only moves when the caller reports a handshake.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       update_i,
    output logic [1:0] gnt_o,
    output logic       last_gnt_o
);

    logic last_gnt_q;

    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_gnt_q ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt_q <= 1'b1;
        end else if (update_i) begin
            last_gnt_q <= gnt_o[1];
        end
    end

    assign last_gnt_o = last_gnt_q;

endmodule

// File: rtl/spi_ram_ctrl_arb.sv
// Round-robin front end for the SPI RAM command port: accepts whole read/write
// transactions from two requesters and issues them as two RAM commands each.
module spi_ram_ctrl_arb
    import spi_ram_ctrl_arb_pkg::*;
#(
    parameter int ADDR_SIZE   = DEF_ADDR_SIZE,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic              clk,
    input  logic              rst,
    spi_ram_ctrl_arb_if.slave bus,
    output state_e            state_o,
    output logic              last_gnt_o
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_e                 state_q;
    logic [ADDR_SIZE+1:0]   din_q;
    logic                   rx_valid_q;
    logic [1:0]             rsp_valid_q;
    logic [ADDR_SIZE-1:0]   rdata_q;
    logic                   err_q;
    logic                   id_q;
    logic [ADDR_SIZE-1:0]   wdata_q;
    logic [CNT_W-1:0]       cnt_q;

    logic [1:0]             gnt;
    logic [1:0]             ready;
    logic                   hs;
    logic                   hs_id;
    logic                   sel_we;
    logic [ADDR_SIZE-1:0]   sel_addr;
    logic [ADDR_SIZE-1:0]   sel_wdata;

    rr_arb2 u_arb (
        .clk        (clk),
        .rst        (rst),
        .req_i      (bus.req_valid),
        .update_i   (hs),
        .gnt_o      (gnt),
        .last_gnt_o (last_gnt_o)
    );

    // Only IDLE can accept, and never while reset is held.
    assign ready     = (state_q == IDLE && !rst) ? gnt : 2'b00;
    assign hs        = |(bus.req_valid & ready);
    assign hs_id     = ready[1];
    assign sel_we    = hs_id ? bus.req_we[1] : bus.req_we[0];
    assign sel_addr  = hs_id ? bus.req_addr[2*ADDR_SIZE-1:ADDR_SIZE]
                             : bus.req_addr[ADDR_SIZE-1:0];
    assign sel_wdata = hs_id ? bus.req_wdata[2*ADDR_SIZE-1:ADDR_SIZE]
                             : bus.req_wdata[ADDR_SIZE-1:0];

    // Each state name describes what is on the RAM bus / response bus while in it,
    // so the registered outputs are loaded on the transition into that state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            din_q       <= '0;
            rx_valid_q  <= 1'b0;
            rsp_valid_q <= 2'b00;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            id_q        <= 1'b0;
            wdata_q     <= '0;
            cnt_q       <= '0;
        end else begin
            rx_valid_q  <= 1'b0;
            rsp_valid_q <= 2'b00;
            case (state_q)
                IDLE: begin
                    if (hs) begin
                        id_q       <= hs_id;
                        wdata_q    <= sel_wdata;
                        rx_valid_q <= 1'b1;
                        if (sel_we) begin
                            din_q   <= {CMD_WR_ADDR, sel_addr};
                            state_q <= WR_ADDR;
                        end else begin
                            din_q   <= {CMD_RD_ADDR, sel_addr};
                            state_q <= RD_ADDR;
                        end
                    end
                end
                WR_ADDR: begin
                    din_q      <= {CMD_WR_DATA, wdata_q};
                    rx_valid_q <= 1'b1;
                    state_q    <= WR_DATA;
                end
                WR_DATA: begin
                    rsp_valid_q <= id_onehot(id_q);
                    rdata_q     <= '0;
                    err_q       <= 1'b0;
                    state_q     <= DONE;
                end
                RD_ADDR: begin
                    din_q      <= {CMD_RD_DATA, {ADDR_SIZE{1'b0}}};
                    rx_valid_q <= 1'b1;
                    state_q    <= RD_CMD;
                end
                RD_CMD: begin
                    cnt_q   <= '0;
                    state_q <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (bus.ram_tx_valid) begin
                        rsp_valid_q <= id_onehot(id_q);
                        rdata_q     <= bus.ram_dout;
                        err_q       <= 1'b0;
                        state_q     <= DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        rsp_valid_q <= id_onehot(id_q);
                        rdata_q     <= '0;
                        err_q       <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready    = ready;
    assign bus.ram_din      = din_q;
    assign bus.ram_rx_valid = rx_valid_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_rdata    = rdata_q;
    assign bus.rsp_err      = err_q;
    assign state_o          = state_q;

endmodule

// File: tb/tb_spi_ram_ctrl_arb.sv
// Bench for spi_ram_ctrl_arb: a behavioural SPI RAM on the command port, a
// reference memory with an expected-response queue, directed and random steps.
module tb_spi_ram_ctrl_arb;
    import spi_ram_ctrl_arb_pkg::*;

    localparam int AW = 8;
    localparam int TO = 4;

    logic   clk = 1'b0;
    logic   rst;
    state_e dbg_state;
    logic   dbg_last_gnt;

    spi_ram_ctrl_arb_if #(.ADDR_SIZE(AW)) bus ();

    spi_ram_ctrl_arb #(.ADDR_SIZE(AW), .TIMEOUT_CYC(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .state_o    (dbg_state),
        .last_gnt_o (dbg_last_gnt)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- SPI RAM model ----------------
    logic [AW-1:0] ram_mem [256];
    logic [AW-1:0] ram_wa;
    logic [AW-1:0] ram_ra;
    logic          block_tx;

    always @(posedge clk) begin
        if (rst) begin
            bus.ram_tx_valid <= 1'b0;
            bus.ram_dout     <= '0;
        end else if (bus.ram_rx_valid) begin
            case (bus.ram_din[AW+1:AW])
                2'b00: begin ram_wa <= bus.ram_din[AW-1:0]; bus.ram_tx_valid <= 1'b0; end
                2'b01: begin ram_mem[ram_wa] <= bus.ram_din[AW-1:0]; bus.ram_tx_valid <= 1'b0; end
                2'b10: begin ram_ra <= bus.ram_din[AW-1:0]; bus.ram_tx_valid <= 1'b0; end
                default: begin
                    bus.ram_dout     <= ram_mem[ram_ra];
                    bus.ram_tx_valid <= !block_tx;
                end
            endcase
        end
    end

    // ---------------- scoreboard state ----------------
    int            n_cmp  = 0;
    int            n_fail = 0;
    logic [AW:0]   exp_q[$];          // {err, rdata}
    logic [AW+1:0] trace_q[$];        // every RAM command seen
    logic [AW-1:0] ref_mem [int];
    logic [AW-1:0] written_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (bus.ram_rx_valid === 1'b1) trace_q.push_back(bus.ram_din);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        bus.req_valid = 2'b11;
        repeat (3) tick();
        #1;
        check("rst_ready", bus.req_ready, 0);
        check("rst_state", dbg_state, IDLE);
        check("rst_rx_valid", bus.ram_rx_valid, 0);
        check("rst_din", bus.ram_din, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rdata", bus.rsp_rdata, 0);
        check("rst_err", bus.rsp_err, 0);
        check("rst_last_gnt", dbg_last_gnt, 1);
        rst = 1'b0;
        bus.req_valid = 2'b00;
        tick();
    endtask

    // One whole transaction from a single requester, checked against the reference.
    task automatic do_txn(input int id, input bit we, input logic [AW-1:0] addr,
                          input logic [AW-1:0] wdata);
        int          lat;
        int          exp_lat;
        logic [AW:0] exp_rsp;
        tick();
        bus.req_valid[id] = 1'b1;
        bus.req_we[id] = we;
        bus.req_addr[id*AW +: AW] = addr;
        bus.req_wdata[id*AW +: AW] = wdata;
        #1;
        check("txn_ready", bus.req_ready, (id == 0) ? 32'd1 : 32'd2);
        if (bus.req_ready[id] !== 1'b1) begin
            bus.req_valid[id] = 1'b0;
            return;
        end
        if (we) begin
            ref_mem[addr] = wdata;
            exp_rsp = '0;
            exp_lat = 3;
        end else if (block_tx) begin
            exp_rsp = {1'b1, {AW{1'b0}}};
            exp_lat = 3 + TO;
        end else begin
            exp_rsp = {1'b0, ref_mem[addr]};
            exp_lat = 4;
        end
        exp_q.push_back(exp_rsp);
        tick();
        bus.req_valid = 2'b00;
        bus.req_we    = 2'($urandom);
        bus.req_addr  = (2*AW)'($urandom);
        bus.req_wdata = (2*AW)'($urandom);
        lat = 1;
        while (bus.rsp_valid === 2'b00 && lat < 3 + TO + 10) begin
            tick();
            lat++;
        end
        exp_rsp = exp_q.pop_front();
        check("txn_latency", lat, exp_lat);
        check("txn_rsp_id", bus.rsp_valid, (id == 0) ? 32'd1 : 32'd2);
        check("txn_err", bus.rsp_err, exp_rsp[AW]);
        if (!exp_rsp[AW]) check("txn_rdata", bus.rsp_rdata, exp_rsp[AW-1:0]);
        tick();
        check("txn_pulse_end", bus.rsp_valid, 0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int            ng;
        int            cyc;
        logic [1:0]    g_val [4];
        int            g_cyc [4];
        logic [1:0]    any_rsp;
        int            rid;
        bit            rwe;
        logic [AW-1:0] raddr;
        logic [AW-1:0] rdat;

        rst = 1'b1;
        block_tx = 1'b0;
        bus.req_valid = 2'b00;
        bus.req_we    = 2'b00;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        apply_reset();

        // Contention straight after reset: R0 first, then strict alternation.
        bus.req_valid = 2'b11;
        bus.req_we    = 2'b11;
        bus.req_addr  = {8'h20, 8'h10};
        bus.req_wdata = {8'h22, 8'h11};
        ng = 0;
        cyc = 0;
        while (ng < 4 && cyc < 30) begin
            #1;
            if (bus.req_ready !== 2'b00) begin
                g_val[ng] = bus.req_ready;
                g_cyc[ng] = cyc;
                ng++;
            end
            tick();
            cyc++;
        end
        bus.req_valid = 2'b00;
        check("arb_grant_count", ng, 4);
        for (int i = 0; i < ng; i++) begin
            check("arb_grant_order", g_val[i], (i % 2 == 0) ? 32'd1 : 32'd2);
            if (i > 0) check("arb_write_spacing", g_cyc[i] - g_cyc[i-1], 4);
        end
        ref_mem[8'h10] = 8'h11;
        ref_mem[8'h20] = 8'h22;
        written_q.push_back(8'h10);
        written_q.push_back(8'h20);
        repeat (5) tick();

        // Basic write then read on R0.
        do_txn(0, 1'b1, 8'h3C, 8'hA5);
        do_txn(0, 1'b0, 8'h3C, 8'h00);
        written_q.push_back(8'h3C);
        do_txn(1, 1'b0, 8'h20, 8'h00);

        // Max address with full command trace.
        trace_q.delete();
        do_txn(1, 1'b1, 8'hFF, 8'h5A);
        do_txn(0, 1'b0, 8'hFF, 8'h00);
        written_q.push_back(8'hFF);
        check("trace_len", trace_q.size(), 4);
        if (trace_q.size() == 4) begin
            check("trace_0", trace_q[0], 10'h0FF);
            check("trace_1", trace_q[1], 10'h15A);
            check("trace_2", trace_q[2], 10'h2FF);
            check("trace_3", trace_q[3], 10'h300);
        end

        // RAM never answers: timeout with err, then a normal read.
        block_tx = 1'b1;
        do_txn(0, 1'b0, 8'h3C, 8'h00);
        block_tx = 1'b0;
        do_txn(0, 1'b0, 8'h3C, 8'h00);

        // Reset while the read command is on the bus.
        tick();
        bus.req_valid = 2'b01;
        bus.req_we    = 2'b00;
        bus.req_addr  = {8'h00, 8'h3C};
        #1;
        check("rstmid_ready", bus.req_ready, 1);
        tick();
        bus.req_valid = 2'b00;
        check("rstmid_rd_addr", dbg_state, RD_ADDR);
        tick();
        check("rstmid_rd_cmd", dbg_state, RD_CMD);
        rst = 1'b1;
        tick();
        check("rstmid_state", dbg_state, IDLE);
        check("rstmid_rx_valid", bus.ram_rx_valid, 0);
        check("rstmid_rsp", bus.rsp_valid, 0);
        bus.req_valid = 2'b01;
        #1;
        check("rstmid_ready_in_rst", bus.req_ready, 0);
        rst = 1'b0;
        bus.req_valid = 2'b00;
        any_rsp = 2'b00;
        repeat (6) begin
            tick();
            any_rsp = any_rsp | bus.rsp_valid;
        end
        check("rstmid_no_rsp", any_rsp, 0);
        do_txn(0, 1'b1, 8'h44, 8'h99);
        do_txn(1, 1'b0, 8'h44, 8'h00);
        written_q.push_back(8'h44);

        // R1 withdraws while R0 is busy; address 0.
        tick();
        bus.req_valid = 2'b01;
        bus.req_we    = 2'b01;
        bus.req_addr  = {8'h55, 8'h00};
        bus.req_wdata = {8'h00, 8'h77};
        #1;
        check("drop_r0_ready", bus.req_ready, 1);
        ref_mem[8'h00] = 8'h77;
        written_q.push_back(8'h00);
        tick();
        bus.req_valid = 2'b10;
        bus.req_we    = 2'b00;
        #1;
        check("drop_busy_ready", bus.req_ready, 0);
        tick();
        bus.req_valid = 2'b00;
        tick();
        check("drop_r0_rsp", bus.rsp_valid, 1);
        any_rsp = 2'b00;
        repeat (6) begin
            tick();
            any_rsp = any_rsp | bus.rsp_valid;
        end
        check("drop_no_extra_rsp", any_rsp, 0);
        check("drop_idle", dbg_state, IDLE);
        do_txn(1, 1'b0, 8'h00, 8'h00);

        // Random traffic against the reference memory.
        for (int k = 0; k < 40; k++) begin
            rid = $urandom_range(0, 1);
            rwe = $urandom_range(0, 1);
            if (rwe) begin
                raddr = AW'($urandom);
                rdat  = AW'($urandom);
                do_txn(rid, 1'b1, raddr, rdat);
                written_q.push_back(raddr);
            end else begin
                raddr = written_q[$urandom_range(0, written_q.size() - 1)];
                block_tx = ($urandom_range(0, 7) == 0);
                do_txn(rid, 1'b0, raddr, 8'h00);
                block_tx = 1'b0;
            end
            repeat ($urandom_range(0, 2)) tick();
        end

        check("final_exp_q_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish by 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
